// File: rtl/fnd_scan_controller_pkg.sv
// Shared constants for the FND scan controller: segment fonts, converter FSM
// encodings, value clamp and double-dabble helper.
package fnd_scan_controller_pkg;

  localparam int unsigned VALUE_W = 14;
  localparam int unsigned BCD_W   = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SHIFTS  = 14;

  localparam logic [VALUE_W-1:0] MAX_VALUE = 14'd9999;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  // Active-low {dp,g,f,e,d,c,b,a}, dp unlit
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  function automatic logic [6:0] seg_of(input logic [3:0] digit);
    logic [7:0] f;
    case (digit)
      4'd0:    f = FONT_0;
      4'd1:    f = FONT_1;
      4'd2:    f = FONT_2;
      4'd3:    f = FONT_3;
      4'd4:    f = FONT_4;
      4'd5:    f = FONT_5;
      4'd6:    f = FONT_6;
      4'd7:    f = FONT_7;
      4'd8:    f = FONT_8;
      4'd9:    f = FONT_9;
      default: f = FONT_BLANK;
    endcase
    return f[6:0];
  endfunction

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_converter_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double dabble, one bit per
// cycle) with start/busy/done handshake.
module bcd_converter_seq
  import fnd_scan_controller_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [VALUE_W-1:0] i_value,
  output logic               o_busy,
  output logic               o_done_c,
  output logic [BCD_W-1:0]   o_bcd,
  output logic [VALUE_W-1:0] o_value
);

  logic [1:0]         r_state, w_state_nxt;
  logic [VALUE_W-1:0] r_bin, w_bin_nxt;
  logic [BCD_W-1:0]   r_bcd, w_bcd_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [VALUE_W-1:0] r_value, w_value_nxt;
  logic               r_busy, w_busy_nxt;
  logic [BCD_W+VALUE_W-1:0] w_shift;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_value <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bin   <= w_bin_nxt;
      r_bcd   <= w_bcd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_value <= w_value_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_bcd_nxt   = r_bcd;
    w_cnt_nxt   = r_cnt;
    w_value_nxt = r_value;
    w_busy_nxt  = r_busy;
    o_done_c    = 1'b0;
    w_shift     = {dd_adjust(r_bcd), r_bin} << 1;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_LOAD;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_LOAD: begin
        w_bin_nxt   = i_value;
        w_value_nxt = i_value;
        w_bcd_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_bcd_nxt = w_shift[BCD_W+VALUE_W-1:VALUE_W];
        w_bin_nxt = w_shift[VALUE_W-1:0];
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(SHIFTS - 1)) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        o_done_c    = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy  = r_busy;
  assign o_bcd   = r_bcd;
  assign o_value = r_value;

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode seven-segment scanner: clamps and converts the input to
// BCD, then advances one digit per rising edge of the synchronised FND clock.
module fnd_scan_controller
  import fnd_scan_controller_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clk_fnd,
  input  logic [VALUE_W-1:0] i_value,
  input  logic [DIGITS-1:0]  i_dp,
  input  logic               i_blank_lz,
  output logic [DIGITS-1:0]  o_fnd_com,
  output logic [7:0]         o_fnd_font,
  output logic               o_busy
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;
  logic [1:0]             r_idx;
  logic [BCD_W-1:0]       r_bcd;
  logic [VALUE_W-1:0]     r_last;
  logic [DIGITS-1:0]      r_com;
  logic [7:0]             r_font;

  logic [VALUE_W-1:0] w_clamped;
  logic               w_start;
  logic               w_pulse;
  logic [1:0]         w_idx_nxt;
  logic [BCD_W-1:0]   w_bcd_nxt;
  logic [VALUE_W-1:0] w_last_nxt;
  logic [3:0]         w_lz;
  logic [3:0]         w_digit;
  logic [6:0]         w_seg;
  logic [DIGITS-1:0]  w_com_nxt;
  logic [7:0]         w_font_nxt;
  logic               w_busy;
  logic               w_done_c;
  logic [BCD_W-1:0]   w_conv_bcd;
  logic [VALUE_W-1:0] w_conv_value;

  bcd_converter_seq u_conv (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (w_start),
    .i_value  (w_clamped),
    .o_busy   (w_busy),
    .o_done_c (w_done_c),
    .o_bcd    (w_conv_bcd),
    .o_value  (w_conv_value)
  );

  // Outputs are built from next-cycle index and BCD so a scan pulse landing on
  // COMMIT shows the new digit immediately.
  always_comb begin
    w_clamped  = (i_value > MAX_VALUE) ? MAX_VALUE : i_value;
    w_start    = (w_clamped != r_last);
    w_pulse    = r_sync[SYNC_STAGES-1] & ~r_dly;
    w_idx_nxt  = r_idx + 2'(w_pulse);
    w_bcd_nxt  = w_done_c ? w_conv_bcd : r_bcd;
    w_last_nxt = w_done_c ? w_conv_value : r_last;
    w_lz[3]    = (w_bcd_nxt[15:12] == 4'd0);
    w_lz[2]    = w_lz[3] & (w_bcd_nxt[11:8] == 4'd0);
    w_lz[1]    = w_lz[2] & (w_bcd_nxt[7:4] == 4'd0);
    w_lz[0]    = 1'b0;
    w_digit    = w_bcd_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_seg      = (i_blank_lz && w_lz[w_idx_nxt]) ? FONT_BLANK[6:0] : seg_of(w_digit);
    w_com_nxt  = ~(DIGITS'(1) << w_idx_nxt);
    w_font_nxt = {~i_dp[w_idx_nxt], w_seg};
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
      r_idx  <= 2'd0;
      r_bcd  <= '0;
      r_last <= '0;
      r_com  <= '1;
      r_font <= 8'hFF;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_clk_fnd};
      r_dly  <= r_sync[SYNC_STAGES-1];
      r_idx  <= w_idx_nxt;
      r_bcd  <= w_bcd_nxt;
      r_last <= w_last_nxt;
      r_com  <= w_com_nxt;
      r_font <= w_font_nxt;
    end
  end

  assign o_fnd_com  = r_com;
  assign o_fnd_font = r_font;
  assign o_busy     = w_busy;

endmodule
